cordic_rotator: RTL

- Iterative fixed-point CORDIC engine in rotation mode.
- Accepts a signed radian angle and returns its cosine and sine after a fixed number of cycles.
- Sits directly downstream of the AXI-Lite register block, inside the CORDIC clock domain, as the arithmetic core driven by the start/done handshake.
- One iteration per clock; quadrant folding extends the convergence range to [-π, π].

---
 rtl/cordic_pkg.sv | 58 +++++
 rtl/cordic_rotator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC rotation engine.
// Holds the controller state encoding, Q.29 angle/gain constants and the
// arctangent table used by the micro-rotations.
package cordic_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FOLD = 3'd1,
        S_ITER = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Q.29 constants
    localparam logic [31:0] PI    = 32'h6487ED51;
    localparam logic [31:0] PI_2  = 32'h3243F6A9;
    localparam logic [31:0] K_INV = 32'h136E9DB4;

    // round(atan(2^-idx) * 2^29)
    function automatic logic [31:0] atan_lut(input logic [4:0] idx);
        logic [31:0] val;
        case (idx)
            5'd0:    val = 32'h1921FB54;
            5'd1:    val = 32'h0ED63383;
            5'd2:    val = 32'h07D6DD7E;
            5'd3:    val = 32'h03FAB753;
            5'd4:    val = 32'h01FF55BB;
            5'd5:    val = 32'h00FFEAAE;
            5'd6:    val = 32'h007FFD55;
            5'd7:    val = 32'h003FFFAB;
            5'd8:    val = 32'h001FFFF5;
            5'd9:    val = 32'h000FFFFF;
            5'd10:   val = 32'h00080000;
            5'd11:   val = 32'h00040000;
            5'd12:   val = 32'h00020000;
            5'd13:   val = 32'h00010000;
            5'd14:   val = 32'h00008000;
            5'd15:   val = 32'h00004000;
            5'd16:   val = 32'h00002000;
            5'd17:   val = 32'h00001000;
            5'd18:   val = 32'h00000800;
            5'd19:   val = 32'h00000400;
            5'd20:   val = 32'h00000200;
            5'd21:   val = 32'h00000100;
            5'd22:   val = 32'h00000080;
            5'd23:   val = 32'h00000040;
            5'd24:   val = 32'h00000020;
            5'd25:   val = 32'h00000010;
            5'd26:   val = 32'h00000008;
            5'd27:   val = 32'h00000004;
            5'd28:   val = 32'h00000002;
            5'd29:   val = 32'h00000001;
            default: val = 32'h00000000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, with
// quadrant folding so any angle in [-pi, pi] converges.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   valid_in, angle_in  start request and Q.FRAC_W angle (radians)
//   ready, busy, done   handshake/status (all registered)
//   cos_out, sin_out    results, held while done=1
//   range_err           |angle_in| > pi; results forced to zero
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 29,
    parameter int unsigned ITER   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] angle_in,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] cos_out,
    output logic [DATA_W-1:0] sin_out,
    output logic              range_err
);

    localparam int unsigned XW = DATA_W + 2;
    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic signed [DATA_W-1:0] PI_S      = DATA_W'(PI);
    localparam logic signed [DATA_W-1:0] PI_2_S    = DATA_W'(PI_2);
    localparam logic signed [DATA_W-1:0] NEG_PI_S  = -PI_S;
    localparam logic signed [DATA_W-1:0] NEG_PI_2S = -PI_2_S;
    localparam logic signed [XW-1:0]     K_X       = XW'(K_INV);
    localparam logic signed [XW-1:0]     ONE_X     = XW'(1) << FRAC_W;
    localparam logic signed [XW-1:0]     NEG_ONE_X = -ONE_X;
    localparam logic [CW-1:0]            LAST      = CW'(ITER - 1);

    state_t                     state;
    logic signed [DATA_W-1:0]   angle_q;
    logic signed [XW-1:0]       x;
    logic signed [XW-1:0]       y;
    logic signed [DATA_W-1:0]   z;
    logic [CW-1:0]              cnt;
    logic                       neg;
    logic                       err;

    logic signed [XW-1:0]       x_sh;
    logic signed [XW-1:0]       y_sh;
    logic signed [DATA_W-1:0]   atan_i;
    logic signed [XW-1:0]       x_post;
    logic signed [XW-1:0]       y_post;

    // Per-iteration shifted operands and table angle
    assign x_sh   = x >>> cnt;
    assign y_sh   = y >>> cnt;
    assign atan_i = DATA_W'(atan_lut(5'(cnt)));

    // Undo the pi fold: cos/sin of (a -/+ pi) are both negated
    assign x_post = neg ? -x : x;
    assign y_post = neg ? -y : y;

    // Clamp to [-1.0, +1.0] and drop the guard bits
    function automatic logic [DATA_W-1:0] sat(input logic signed [XW-1:0] v);
        logic [DATA_W-1:0] r;
        if (v > ONE_X) begin
            r = DATA_W'(ONE_X);
        end else if (v < NEG_ONE_X) begin
            r = DATA_W'(NEG_ONE_X);
        end else begin
            r = DATA_W'(v);
        end
        return r;
    endfunction

    // Controller and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            angle_q   <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            err       <= 1'b0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            cos_out   <= '0;
            sin_out   <= '0;
            range_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (valid_in) begin
                        angle_q   <= angle_in;
                        done      <= 1'b0;
                        range_err <= 1'b0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_FOLD;
                    end
                end
                S_FOLD: begin
                    if (angle_q > PI_2_S) begin
                        z   <= angle_q - PI_S;
                        neg <= 1'b1;
                    end else if (angle_q < NEG_PI_2S) begin
                        z   <= angle_q + PI_S;
                        neg <= 1'b1;
                    end else begin
                        z   <= angle_q;
                        neg <= 1'b0;
                    end
                    err   <= (angle_q > PI_S) || (angle_q < NEG_PI_S);
                    x     <= K_X;
                    y     <= '0;
                    cnt   <= '0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    // Rotate toward z = 0; y update uses the pre-update x
                    if (!z[DATA_W-1]) begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan_i;
                    end else begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan_i;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= S_POST;
                    end
                end
                S_POST: begin
                    if (err) begin
                        cos_out   <= '0;
                        sin_out   <= '0;
                        range_err <= 1'b1;
                    end else begin
                        cos_out   <= sat(x_post);
                        sin_out   <= sat(y_post);
                        range_err <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
